// File: rtl/char_mover.sv
// Grid-position engine for one game character: periodic one-cell step attempts,
// an edge check, a wall query to the maze map, then commit or reject.
module char_mover #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 12,
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int STEP_CYCLES = 4,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        charDir,
  input  logic              go,
  input  logic              respawn,
  output logic              q_valid,
  output logic [X_BITS-1:0] q_x,
  output logic [Y_BITS-1:0] q_y,
  input  logic              q_ack,
  input  logic              q_wall,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic              moved,
  output logic              bumped,
  output logic              busy
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_QUERY} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [X_BITS-1:0]  r_pos_x;
  logic [Y_BITS-1:0]  r_pos_y;
  logic [X_BITS-1:0]  r_q_x;
  logic [Y_BITS-1:0]  r_q_y;
  logic               r_q_valid;
  logic               r_moved;
  logic               r_bumped;

  logic [X_BITS-1:0]  w_tgt_x;
  logic [Y_BITS-1:0]  w_tgt_y;
  logic               w_off_grid;
  logic               w_settle;

  always_comb begin
    w_tgt_x    = r_pos_x;
    w_tgt_y    = r_pos_y;
    w_off_grid = 1'b0;
    unique case (charDir)
      2'b00: begin
        w_off_grid = (r_pos_y == '0);
        w_tgt_y    = r_pos_y - 1'b1;
      end
      2'b01: begin
        w_off_grid = (r_pos_y == Y_BITS'(GRID_H - 1));
        w_tgt_y    = r_pos_y + 1'b1;
      end
      2'b10: begin
        w_off_grid = (r_pos_x == '0);
        w_tgt_x    = r_pos_x - 1'b1;
      end
      2'b11: begin
        w_off_grid = (r_pos_x == X_BITS'(GRID_W - 1));
        w_tgt_x    = r_pos_x + 1'b1;
      end
    endcase
  end

  // The cycle carrying a moved/bumped pulse is a settle cycle: the step
  // counter holds at 0 there, giving a STEP_CYCLES+2 minimum step period.
  assign w_settle = r_moved | r_bumped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pos_x   <= X_BITS'(START_X);
      r_pos_y   <= Y_BITS'(START_Y);
      r_q_x     <= '0;
      r_q_y     <= '0;
      r_q_valid <= 1'b0;
      r_moved   <= 1'b0;
      r_bumped  <= 1'b0;
    end else begin
      r_moved  <= 1'b0;
      r_bumped <= 1'b0;
      if (respawn) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_pos_x   <= X_BITS'(START_X);
        r_pos_y   <= Y_BITS'(START_Y);
        r_q_valid <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (!go || w_settle) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
              r_cnt <= '0;
              if (w_off_grid) begin
                r_bumped <= 1'b1;
              end else begin
                r_q_x     <= w_tgt_x;
                r_q_y     <= w_tgt_y;
                r_q_valid <= 1'b1;
                r_state   <= S_QUERY;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_QUERY: begin
            if (q_ack) begin
              r_q_valid <= 1'b0;
              r_state   <= S_IDLE;
              if (q_wall) begin
                r_bumped <= 1'b1;
              end else begin
                r_pos_x <= r_q_x;
                r_pos_y <= r_q_y;
                r_moved <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign q_valid = r_q_valid;
  assign q_x     = r_q_x;
  assign q_y     = r_q_y;
  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign moved   = r_moved;
  assign bumped  = r_bumped;
  assign busy    = (r_state == S_QUERY);

endmodule

// File: tb/tb_char_mover.sv
// Directed bench for char_mover: moved/bumped events are predicted into a
// scoreboard queue and retired by a monitor when the pulses appear.
module tb_char_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] charDir;
  logic       go, respawn, q_ack, q_wall;
  logic       q_valid, moved, bumped, busy;
  logic [3:0] q_x, q_y, pos_x, pos_y;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] mx, my;

  typedef struct packed {
    logic       mv;
    logic [3:0] x;
    logic [3:0] y;
  } ev_t;
  ev_t exp_q[$];

  char_mover #(
    .GRID_W(16), .GRID_H(12), .X_BITS(4), .Y_BITS(4),
    .STEP_CYCLES(4), .START_X(2), .START_Y(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .charDir(charDir), .go(go), .respawn(respawn),
    .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_ack(q_ack), .q_wall(q_wall),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .bumped(bumped), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic mv, input logic [3:0] x, input logic [3:0] y);
    ev_t e;
    e.mv = mv;
    e.x  = x;
    e.y  = y;
    exp_q.push_back(e);
  endtask

  // Retire predicted events as the pulses show up.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (moved || bumped)) begin
      chk("pulse_exclusive", {31'd0, moved & bumped}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, moved, bumped}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", {30'd0, moved, bumped}, {30'd0, e.mv, ~e.mv});
        chk("event_pos", {24'd0, pos_x, pos_y}, {24'd0, e.x, e.y});
      end
    end
  end

  task automatic wait_qv(output int n);
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("qv_timeout", q_valid, 1);
  endtask

  task automatic answer(input int waits, input logic wall, input logic [3:0] tx, input logic [3:0] ty);
    chk("q_x", q_x, tx);
    chk("q_y", q_y, ty);
    chk("busy_query", busy, 1);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("qv_held", q_valid, 1);
      chk("qx_held", q_x, tx);
      chk("qy_held", q_y, ty);
    end
    q_ack  = 1'b1;
    q_wall = wall;
    if (wall) push_ev(1'b0, mx, my);
    else begin
      push_ev(1'b1, tx, ty);
      mx = tx;
      my = ty;
    end
    tick();
    q_ack  = 1'b0;
    q_wall = 1'b0;
    chk("qv_drop", q_valid, 0);
    chk("busy_drop", busy, 0);
    chk("pos_x", pos_x, mx);
    chk("pos_y", pos_y, my);
  endtask

  task automatic step(input logic [1:0] dir, input int exp_wait, input int waits, input logic wall);
    logic [3:0] tx, ty;
    int n;
    tx = mx;
    ty = my;
    case (dir)
      2'b00: ty = my - 4'd1;
      2'b01: ty = my + 4'd1;
      2'b10: tx = mx - 4'd1;
      default: tx = mx + 4'd1;
    endcase
    charDir = dir;
    go = 1'b1;
    wait_qv(n);
    chk("qv_latency", n, exp_wait);
    answer(waits, wall, tx, ty);
  endtask

  task automatic bump_check(input logic [1:0] dir, input int n);
    charDir = dir;
    go = 1'b1;
    for (int k = 0; k < n; k++) begin
      push_ev(1'b0, mx, my);
      for (int t = 0; t < ((k == 0) ? 3 : 4); t++) begin
        tick();
        chk("bump_gap", bumped, 0);
        chk("bump_noq", q_valid, 0);
      end
      tick();
      chk("bump_pulse", bumped, 1);
      chk("bump_noq2", q_valid, 0);
      chk("bump_pos", {28'd0, pos_x, pos_y}, {28'd0, mx, my});
    end
    go = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; charDir = 2'b00; go = 1'b0; respawn = 1'b0;
    q_ack = 1'b0; q_wall = 1'b0;
    mx = 4'd2; my = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos_x", pos_x, 2);
    chk("rst_pos_y", pos_y, 3);
    chk("rst_q", {26'd0, q_valid, q_x, q_y}, 0);
    chk("rst_flags", {29'd0, moved, bumped, busy}, 0);
    rst_n = 1'b1;

    // First step right with a one-cycle map, then repeat rate, then zero-wait.
    step(2'b11, 4, 1, 1'b0);
    step(2'b11, 5, 1, 1'b0);
    step(2'b11, 5, 0, 1'b0);
    go = 1'b0;

    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    mx = 4'd2; my = 4'd3;
    chk("respawn_pos", {24'd0, pos_x, pos_y}, 32'h23);

    // Wall below after three wait cycles.
    step(2'b01, 4, 3, 1'b1);

    // Input changes during QUERY do not disturb the pending query.
    wait_qv(n);
    chk("qv_latency_settle", n, 5);
    charDir = 2'b10;
    go = 1'b0;
    answer(2, 1'b0, 4'd2, 4'd4);
    repeat (3) begin
      tick();
      chk("go_low_idle", q_valid, 0);
    end
    step(2'b10, 4, 0, 1'b0);
    step(2'b10, 5, 0, 1'b0);
    go = 1'b0;
    tick();
    bump_check(2'b10, 3);

    for (int i = 0; i < 4; i++) step(2'b00, (i == 0) ? 4 : 5, 0, 1'b0);
    go = 1'b0;
    tick();
    bump_check(2'b00, 3);
    bump_check(2'b10, 3);

    for (int i = 0; i < 11; i++) step(2'b01, (i == 0) ? 4 : 5, 0, 1'b0);
    go = 1'b0;
    tick();
    bump_check(2'b01, 3);

    for (int i = 0; i < 15; i++) step(2'b11, (i == 0) ? 4 : 5, 0, 1'b0);
    go = 1'b0;
    tick();
    bump_check(2'b11, 3);

    // Respawn in the same cycle as a clean ack wins.
    charDir = 2'b10;
    go = 1'b1;
    wait_qv(n);
    chk("qv_latency_r", n, 4);
    chk("q_xy_r", {24'd0, q_x, q_y}, 32'hEB);
    q_ack = 1'b1;
    respawn = 1'b1;
    tick();
    q_ack = 1'b0;
    respawn = 1'b0;
    mx = 4'd2; my = 4'd3;
    chk("resp_pos", {24'd0, pos_x, pos_y}, 32'h23);
    chk("resp_flags", {28'd0, moved, bumped, q_valid, busy}, 0);
    step(2'b11, 4, 0, 1'b0);

    // Asynchronous reset in the middle of a query.
    wait_qv(n);
    chk("qv_latency_a", n, 5);
    chk("q_x_a", q_x, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos", {24'd0, pos_x, pos_y}, 32'h23);
    chk("arst_q", {26'd0, q_valid, q_x, q_y}, 0);
    chk("arst_flags", {29'd0, moved, bumped, busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go = 1'b0;
    mx = 4'd2; my = 4'd3;
    q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
    chk("late_ack_q", {30'd0, q_valid, busy}, 0);
    chk("late_ack_pos", {24'd0, pos_x, pos_y}, 32'h23);
    tick();
    chk("late_ack_moved", moved, 0);

    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_mover.md
# char_mover

Grid-position engine for one game character (cat or mouse). Consumes the 2-bit `charDir` produced by the direction converter. At a fixed step rate it proposes a one-cell move, queries the maze map for a wall at the target cell, then commits or rejects the move. Sits between the direction converter and the collision/render logic, which read `pos_x`/`pos_y`.

## Interface
- `GRID_W`, 16: grid width in cells; x range 0..GRID_W-1
- `GRID_H`, 12: grid height in cells; y range 0..GRID_H-1
- `X_BITS`, 4: width of x coordinates
- `Y_BITS`, 4: width of y coordinates
- `STEP_CYCLES`, 4: enabled IDLE cycles per step attempt (≥2)
- `START_X`, 0: reset/respawn x
- `START_Y`, 0: respawn/reset y
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `charDir`  in  2  00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1); origin top-left
- `go`  in  1  movement enable; 0 freezes the step counter
- `respawn`  in  1  synchronous teleport to (START_X, START_Y)
- `q_valid`  out  1  map query pending
- `q_x`  out  X_BITS  queried cell x
- `q_y`  out  Y_BITS  queried cell y
- `q_ack`  in  1  map response valid; sampled only while `q_valid`=1
- `q_wall`  in  1  1 = queried cell is a wall; valid with `q_ack`
- `pos_x`  out  X_BITS  current x
- `pos_y`  out  Y_BITS  current y
- `moved`  out  1  one-cycle pulse: position just changed
- `bumped`  out  1  one-cycle pulse: move rejected (edge or wall)
- `busy`  out  1  1 while in QUERY

## Operation
- States: IDLE, QUERY.
- IDLE, `go`=1: `cnt` increments each cycle.
- IDLE, `go`=0: `cnt` clears to 0.
- IDLE, `go`=1 and `cnt`==STEP_CYCLES-1: step attempt. `charDir` is latched and target = pos ± 1 on the selected axis; `cnt` clears.
- Edge rule: target is off-grid when moving up at y=0, down at y=GRID_H-1, left at x=0, or right at x=GRID_W-1. An off-grid target gives `bumped`=1 next cycle, no query, and the FSM stays in IDLE. Coordinates never wrap.
- In-grid target: next cycle `q_valid`=1, `q_x`/`q_y` = target, and the FSM enters QUERY.
- QUERY: `q_valid`, `q_x` and `q_y` are held stable until `q_ack`=1 is sampled. Changes on `charDir` and `go` are ignored. No timeout.
- `q_ack`=1 with `q_wall`=0: next edge `pos` ← target, `moved`=1, `q_valid`=0, FSM → IDLE.
- `q_ack`=1 with `q_wall`=1: next edge `pos` unchanged, `bumped`=1, `q_valid`=0, FSM → IDLE.
- `q_ack` is ignored while `q_valid`=0.
- `respawn`=1, any state, highest priority. Next edge: `pos` = START, FSM → IDLE, `cnt`=0, `q_valid`=0, no `moved`/`bumped`. An ack arriving in the same cycle is discarded.
- `busy` = (state==QUERY).
- `moved` and `bumped` are never high in the same cycle.

## Timing
- Reset values (`rst_n`=0, asynchronous): `pos_x`=START_X, `pos_y`=START_Y, `q_valid`=0, `q_x`=0, `q_y`=0, `moved`=0, `bumped`=0, `busy`=0, state IDLE, `cnt`=0.
- Reset asserted mid-QUERY aborts the query immediately; any later `q_ack` is ignored.
- From `go` rising in IDLE, the attempt occurs on the STEP_CYCLES-th enabled cycle. `q_valid` or `bumped` appears 1 cycle later.
- Commit: `pos` and `moved` update on the edge after the `q_ack` cycle.
- Minimum step period = STEP_CYCLES + 2 cycles, with a zero-wait map. `cnt` restarts from 0 on return to IDLE.
- All outputs are registered.

## Test plan
- Params: STEP_CYCLES=4, START=(2,3). Reset, `go`=1, `charDir`=11, map acks 1 cycle after `q_valid` with `q_wall`=0 → `q_valid` with `q_x`=3, `q_y`=3 on cycle 5. Then `pos`=(3,3) with a `moved` pulse, and steps repeat every 7 cycles.
- START=(0,0), `charDir`=00, `go`=1 → `bumped` pulse every 5 cycles, `q_valid` never asserts, `pos` stays (0,0). Repeat with `charDir`=10, same result.
- `pos`=(2,3), `charDir`=01, map returns `q_wall`=1 after 3 wait cycles → `q_valid` held 4 cycles with `q_y`=4, then `bumped`=1 and `pos` stays (2,3).
- During QUERY, `charDir` changes 01→10 and `go` drops → query target unchanged; after ack, `pos`=(2,4). Next attempt happens only after `go`=1 for 4 more cycles, and uses left.
- `respawn` pulsed in the same cycle as `q_ack`(`q_wall`=0) from (5,5) → `pos`=(2,3), no `moved`, `q_valid`=0, `cnt`=0.
- `rst_n` asserted asynchronously mid-QUERY → all outputs take reset values immediately. A late `q_ack` after release causes no move.
